// File: rtl/fetch_align_pkg.sv
// Shared types and helpers for the RV32IC fetch-alignment controller.
package fetch_align_pkg;

  typedef enum logic [1:0] {
    ALIGNED = 2'd0,
    BUF     = 2'd1,
    NOBUF   = 2'd2
  } fa_state_e;

  localparam logic [1:0] OP_FULL = 2'b11;

  function automatic logic is_compressed(input logic [15:0] h);
    return h[1:0] != OP_FULL;
  endfunction

endpackage

// File: rtl/fa_halfword_buf.sv
// 16-bit halfword holding register; clear wins over load.
module fa_halfword_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [15:0] i_data,
  output logic [15:0] o_data
);

  logic [15:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/fetch_align_ctrl.sv
// Splits 32-bit IMEM words into a halfword-aligned 16/32-bit instruction stream.
// Only XLEN = 32 is supported.
module fetch_align_ctrl
  import fetch_align_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] fetch_addr_o,
  input  logic [XLEN-1:0] fetch_rdata_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o,
  output logic            compressed_o,
  output logic            bubble_o,
  output logic            misalign_err_o,
  output fa_state_e       dbg_state_o
);

  localparam fa_state_e RESET_STATE = RESET_PC[1] ? NOBUF : ALIGNED;

  fa_state_e       r_state_q;
  fa_state_e       w_state_d;
  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] w_pc_d;
  logic [15:0]     w_buf_q;
  logic            w_buf_load;
  logic            w_buf_clear;
  logic [XLEN-1:0] w_instr;
  logic            w_comp;
  logic            w_bubble;

  fa_halfword_buf u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_data  (fetch_rdata_i[31:16]),
    .o_data  (w_buf_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_q <= RESET_STATE;
      r_pc_q    <= RESET_PC;
    end else begin
      r_state_q <= w_state_d;
      r_pc_q    <= w_pc_d;
    end
  end

  always_comb begin
    w_state_d   = r_state_q;
    w_pc_d      = r_pc_q;
    w_buf_load  = 1'b0;
    w_buf_clear = 1'b0;
    w_instr     = '0;
    w_comp      = 1'b0;
    w_bubble    = 1'b0;

    case (r_state_q)
      ALIGNED: begin
        if (is_compressed(fetch_rdata_i[15:0])) begin
          w_instr    = {16'h0, fetch_rdata_i[15:0]};
          w_comp     = 1'b1;
          w_buf_load = 1'b1;
          w_pc_d     = r_pc_q + XLEN'(2);
          w_state_d  = BUF;
        end else begin
          w_instr = fetch_rdata_i;
          w_pc_d  = r_pc_q + XLEN'(4);
        end
      end
      BUF: begin
        // A compressed buffered halfword retires without touching the IMEM word.
        if (is_compressed(w_buf_q)) begin
          w_instr   = {16'h0, w_buf_q};
          w_comp    = 1'b1;
          w_pc_d    = r_pc_q + XLEN'(2);
          w_state_d = ALIGNED;
        end else begin
          w_instr    = {fetch_rdata_i[15:0], w_buf_q};
          w_buf_load = 1'b1;
          w_pc_d     = r_pc_q + XLEN'(4);
        end
      end
      NOBUF: begin
        if (is_compressed(fetch_rdata_i[31:16])) begin
          w_instr   = {16'h0, fetch_rdata_i[31:16]};
          w_comp    = 1'b1;
          w_pc_d    = r_pc_q + XLEN'(2);
          w_state_d = ALIGNED;
        end else begin
          // Lower half of a straddling instruction: park it and spend one bubble.
          w_buf_load = 1'b1;
          w_bubble   = 1'b1;
          w_state_d  = BUF;
        end
      end
      default: begin
        w_state_d = ALIGNED;
      end
    endcase

    if (redirect_i) begin
      w_pc_d      = {redirect_pc_i[XLEN-1:1], 1'b0};
      w_state_d   = redirect_pc_i[1] ? NOBUF : ALIGNED;
      w_buf_load  = 1'b0;
      w_buf_clear = 1'b1;
    end else if (stall_i) begin
      w_pc_d     = r_pc_q;
      w_state_d  = r_state_q;
      w_buf_load = 1'b0;
    end
  end

  assign fetch_addr_o   = (r_state_q == BUF) ? (r_pc_q + XLEN'(2))
                                             : {r_pc_q[XLEN-1:2], 2'b00};
  assign pc_o           = r_pc_q;
  assign instr_o        = reset_n ? w_instr : '0;
  assign compressed_o   = reset_n & w_comp;
  assign bubble_o       = reset_n & w_bubble & !stall_i;
  assign instr_valid_o  = reset_n & !redirect_i & !stall_i & !w_bubble;
  assign misalign_err_o = reset_n & redirect_i & redirect_pc_i[0];
  assign dbg_state_o    = r_state_q;

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl against a small combinational IMEM model.
module tb_fetch_align_ctrl;
  import fetch_align_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] fetch_addr_o;
  logic [31:0] fetch_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        compressed_o;
  logic        bubble_o;
  logic        misalign_err_o;
  fa_state_e   dbg_state_o;

  logic [31:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  fetch_align_ctrl #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_rdata_i  (fetch_rdata_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .instr_valid_o  (instr_valid_o),
    .compressed_o   (compressed_o),
    .bubble_o       (bubble_o),
    .misalign_err_o (misalign_err_o),
    .dbg_state_o    (dbg_state_o)
  );

  assign fetch_rdata_i = mem[fetch_addr_o[9:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] e_instr,
                              input logic [31:0] e_pc, input logic e_comp);
    check({tag, ".valid"}, 32'(instr_valid_o), 32'd1);
    check({tag, ".instr"}, instr_o, e_instr);
    check({tag, ".pc"},    pc_o, e_pc);
    check({tag, ".comp"},  32'(compressed_o), 32'(e_comp));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h0000_0013;
    mem[8'h01] = 32'h4505_0001;
    mem[8'h02] = 32'h0513_0001;
    mem[8'h03] = 32'h0000_0010;
    mem[8'h04] = 32'h0000_0013;
    mem[8'h40] = 32'h0513_0000;
    mem[8'h41] = 32'h0000_0010;
    mem[8'h80] = 32'h0000_0013;
    mem[8'hFF] = 32'h0001_0000;

    // Reset values
    #3;
    check("rst.valid",  32'(instr_valid_o), 32'd0);
    check("rst.instr",  instr_o, 32'h0);
    check("rst.pc",     pc_o, 32'h0);
    check("rst.bubble", 32'(bubble_o), 32'd0);
    check("rst.state",  32'(dbg_state_o), 32'(ALIGNED));
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    settle();

    // Full aligned instruction
    expect_instr("full", 32'h0000_0013, 32'h0, 1'b0);
    check("full.faddr", fetch_addr_o, 32'h0);
    next_cycle(); settle();

    // Two compressed in one word
    expect_instr("c2a", 32'h0000_0001, 32'h4, 1'b1);
    next_cycle(); settle();
    check("c2b.faddr", fetch_addr_o, 32'h8);
    check("c2b.state", 32'(dbg_state_o), 32'(BUF));
    expect_instr("c2b", 32'h0000_4505, 32'h6, 1'b1);
    next_cycle(); settle();

    // Straddle without bubble
    check("str.state0", 32'(dbg_state_o), 32'(ALIGNED));
    expect_instr("str.c", 32'h0000_0001, 32'h8, 1'b1);
    next_cycle();

    // Stall in BUF for three cycles
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall.valid",  32'(instr_valid_o), 32'd0);
      check("stall.pc",     pc_o, 32'hA);
      check("stall.instr",  instr_o, 32'h0010_0513);
      check("stall.bubble", 32'(bubble_o), 32'd0);
      check("stall.state",  32'(dbg_state_o), 32'(BUF));
      next_cycle();
    end
    stall_i = 1'b0;
    settle();
    expect_instr("str.full", 32'h0010_0513, 32'hA, 1'b0);
    check("str.state1", 32'(dbg_state_o), 32'(BUF));
    next_cycle(); settle();
    expect_instr("str.tail", 32'h0000_0000, 32'hE, 1'b1);
    check("str.faddr", fetch_addr_o, 32'h10);
    next_cycle();

    // Redirect into a straddling instruction
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    settle();
    check("rd.valid", 32'(instr_valid_o), 32'd0);
    check("rd.mis",   32'(misalign_err_o), 32'd0);
    next_cycle();
    redirect_i = 1'b0;
    settle();
    check("rd.bubble", 32'(bubble_o), 32'd1);
    check("rd.bvalid", 32'(instr_valid_o), 32'd0);
    check("rd.bpc",    pc_o, 32'h102);
    check("rd.faddr",  fetch_addr_o, 32'h100);
    check("rd.state",  32'(dbg_state_o), 32'(NOBUF));
    next_cycle(); settle();
    expect_instr("rd.instr", 32'h0010_0513, 32'h102, 1'b0);
    check("rd.bubble1", 32'(bubble_o), 32'd0);
    next_cycle();

    // Redirect together with stall, misaligned target
    redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h201;
    settle();
    check("rs.mis",   32'(misalign_err_o), 32'd1);
    check("rs.valid", 32'(instr_valid_o), 32'd0);
    next_cycle();
    redirect_i = 1'b0; stall_i = 1'b0;
    settle();
    check("rs.mis1",  32'(misalign_err_o), 32'd0);
    check("rs.state", 32'(dbg_state_o), 32'(ALIGNED));
    expect_instr("rs.instr", 32'h0000_0013, 32'h200, 1'b0);
    next_cycle();

    // Redirect during the NOBUF bubble cancels the BUF transition
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    settle();
    next_cycle();
    redirect_i = 1'b0;
    settle();
    check("rb.bubble", 32'(bubble_o), 32'd1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0;
    settle();
    check("rb.valid", 32'(instr_valid_o), 32'd0);
    next_cycle();
    redirect_i = 1'b0;
    settle();
    check("rb.state", 32'(dbg_state_o), 32'(ALIGNED));
    expect_instr("rb.instr", 32'h0000_0013, 32'h0, 1'b0);
    next_cycle();

    // PC wrap at the top of the address space
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    settle();
    next_cycle();
    redirect_i = 1'b0;
    settle();
    check("wrap.faddr", fetch_addr_o, 32'hFFFF_FFFC);
    expect_instr("wrap.c", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    next_cycle(); settle();
    expect_instr("wrap.0", 32'h0000_0013, 32'h0, 1'b0);
    next_cycle(); settle();

    // Reset asserted while in BUF
    expect_instr("mr.c", 32'h0000_0001, 32'h4, 1'b1);
    next_cycle(); settle();
    check("mr.buf", 32'(dbg_state_o), 32'(BUF));
    reset_n = 1'b0;
    #1;
    check("mr.valid", 32'(instr_valid_o), 32'd0);
    check("mr.instr", instr_o, 32'h0);
    check("mr.pc",    pc_o, 32'h0);
    check("mr.state", 32'(dbg_state_o), 32'(ALIGNED));
    next_cycle();
    reset_n = 1'b1;
    settle();
    expect_instr("mr.after", 32'h0000_0013, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_align_ctrl.md
# fetch_align_ctrl

Fetch-alignment controller for the RV32IC front end. It turns 32-bit word reads from a combinational instruction memory into a stream of halfword-aligned 16/32-bit instructions, one per cycle. A halfword buffer and a three-state FSM carry the upper half of a word across cycles. It drives the fetch address and PC and raises the compressed-fetch bubble when a 32-bit instruction straddles a word after a redirect. It sits between the PC/IMEM port and the decompressor/decode stage.

## Interface
- `XLEN`, 32: address/data width; only 32 is supported.
- `RESET_PC`, 32'h0000_0000: PC after reset; bit 0 must be 0.

- `clk` input 1: core clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `stall_i` input 1: downstream hold; freeze all state.
- `redirect_i` input 1: branch/jump/trap redirect, one-cycle pulse.
- `redirect_pc_i` input 32: redirect target, halfword-aligned.
- `fetch_addr_o` output 32: word-aligned IMEM address.
- `fetch_rdata_i` input 32: IMEM word at `fetch_addr_o`, valid in the same cycle.
- `instr_o` output 32: raw instruction; upper 16 bits are zero when compressed.
- `pc_o` output 32: address of `instr_o`.
- `instr_valid_o` output 1: `instr_o`/`pc_o` valid this cycle.
- `compressed_o` output 1: `instr_o` is 16-bit (low bits != 2'b11).
- `bubble_o` output 1: straddle bubble; no instruction this cycle.
- `misalign_err_o` output 1: one-cycle pulse when `redirect_pc_i[0]` = 1.

## Operation
- Registers: `pc_q` (32), `buf_q` (16), `state_q`.
- Compressed test: halfword h is compressed iff h[1:0] != 2'b11.
- `fetch_addr_o` = {pc_q[31:2], 2'b00} in ALIGNED and NOBUF. In BUF it is `pc_q + 2`, the next word.
- ALIGNED (pc_q[1] = 0), W = `fetch_rdata_i`:
  - If W[15:0] is compressed: instr = W[15:0], buf_q <= W[31:16], pc += 2, go to BUF.
  - Otherwise: instr = W, pc += 4, stay in ALIGNED.
- BUF (pc_q[1] = 1, buf_q holds the halfword at pc_q):
  - If buf_q is compressed: instr = buf_q, pc += 2, go to ALIGNED. The IMEM word is unused this cycle.
  - Otherwise: instr = {W[15:0], buf_q}, buf_q <= W[31:16], pc += 4, stay in BUF.
- NOBUF (pc_q[1] = 1, buffer empty; entered only via redirect or reset):
  - If W[31:16] is compressed: instr = W[31:16], pc += 2, go to ALIGNED.
  - Otherwise: buf_q <= W[31:16], pc unchanged, `bubble_o` = 1, `instr_valid_o` = 0, go to BUF.
- `instr_valid_o` = !redirect_i && !stall_i && !bubble_o && reset released.
- Redirect has priority over stall and over the normal update:
  - pc_q <= {redirect_pc_i[31:1], 1'b0}.
  - state <= redirect_pc_i[1] ? NOBUF : ALIGNED.
  - buf_q is discarded; `instr_valid_o` = 0 that cycle.
  - `misalign_err_o` = redirect_i & redirect_pc_i[0], combinational.
- Stall (no redirect): pc_q, buf_q and state hold. `instr_o`/`pc_o` stay stable because the IMEM address is unchanged. `bubble_o` is forced to 0 and `instr_valid_o` = 0.
- PC arithmetic is modulo 2^32, so 0xFFFF_FFFE + 2 wraps to 0. No fault is raised.

## Timing
- Reset values:
  - pc_q = RESET_PC; state = RESET_PC[1] ? NOBUF : ALIGNED; buf_q = 0.
  - All outputs except `fetch_addr_o`/`pc_o` are 0 during reset.
- Latency: the instruction is produced in the same cycle as its fetch address. Throughput is one instruction per cycle.
- Exception: a straddling 32-bit instruction after a redirect costs exactly one bubble cycle.
- Redirect latency: the first instruction from the target is valid the cycle after `redirect_i`.
- Reset asserted mid-sequence (e.g. in BUF) drops the buffer immediately; nothing is replayed.
- A redirect pulse asserted during the NOBUF bubble cycle is honoured and cancels the BUF transition.

## Structure
- Package `fetch_align_pkg`:
  - `typedef enum logic [1:0] {ALIGNED, BUF, NOBUF} fa_state_e`.
  - `localparam logic [1:0] OP_FULL = 2'b11`.
  - Function `is_compressed(logic [15:0])`.
- One sub-module, `fa_halfword_buf`: a 16-bit register with load/hold/clear, asynchronous reset. The FSM, PC and muxes live in the top.

## Test plan
- Full aligned: RESET_PC = 0, word@0 = 0x0000_0013 -> cycle 1: instr 0x00000013, pc 0, compressed 0; next fetch_addr 0x4.
- Two compressed: word@0 = 0x4505_0001 -> instr 0x0001 @pc 0, then 0x4505 @pc 2 with no IMEM dependence, then fetch_addr 0x4 in ALIGNED.
- Straddle, no bubble: word@0 = 0x0513_0001, word@4 = 0x0000_0010 -> 0x0001 @0, then 0x00100513 @2 in one cycle, state stays BUF.
- Redirect straddle: redirect to 0x102, word@0x100 = 0x0513_xxxx, word@0x104 = 0x0000_0010 -> next cycle bubble_o = 1, valid 0; following cycle instr 0x00100513 @0x102.
- Stall: stall_i held 3 cycles in BUF -> pc_o, instr_o and buf_q unchanged, valid 0; the stream resumes with no lost or duplicated instruction.
- Redirect + stall in the same cycle, redirect_pc = 0x201 -> redirect wins, pc 0x200, misalign_err_o pulses for 1 cycle, state ALIGNED.
